// File: rtl/intermission_seq.sv
// -----------------------------------------------------------------------------
// intermission_seq
//
// Bus-integration / intermission sequencer for a CAN-style controller. It
// decides when the bus is idle, when a frame is in progress, and when the
// local node may start transmitting. Bit timing comes from an external bit
// counter, which this block drives and reads back.
//
// Optional feature: define the macro SUSPEND_TX_EN to add the SUSPEND state.
// In that state an error-passive node that sent the last frame waits 8 extra
// recessive bits before it may transmit again. When the macro is undefined,
// SUSPEND is not built, INTERM always exits to IDLE, and state code 4 is
// treated as illegal.
//
// Ports
//   clock          in   system clock, all flops on the rising edge
//   reset          in   asynchronous active-high reset
//   Prescale_EN    in   time-quantum enable; every update is qualified by it
//   sample_pt      in   bit sample strobe (bit event = sample_pt & Prescale_EN)
//   rx_bit         in   sampled bus level, 1 = recessive
//   eof_done       in   end-of-frame field finished (single-cycle pulse)
//   tx_request     in   a local frame is pending
//   was_tx         in   this node transmitted the last frame
//   error_passive  in   node is error passive
//   counto[6:0]    in   external bit-counter value
//   eq3, eq11      in   external bit-counter compare flags
//   cnt_inc        out  bit-counter increment (the counter acts on its rising edge)
//   cnt_rst_n      out  bit-counter synchronous clear, active-low
//   bus_idle       out  bus is idle (IDLE state)
//   frame_active   out  a frame is in progress (ACTIVE state)
//   tx_start       out  one-quantum pulse: start local transmission (SOF)
//   overload_req   out  one-quantum pulse: overload frame required
//   state[2:0]     out  current state code
// -----------------------------------------------------------------------------
module intermission_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       Prescale_EN,
    input  logic       sample_pt,
    input  logic       rx_bit,
    input  logic       eof_done,
    input  logic       tx_request,
    input  logic       was_tx,
    input  logic       error_passive,
    input  logic [6:0] counto,
    input  logic       eq3,
    input  logic       eq11,
    output logic       cnt_inc,
    output logic       cnt_rst_n,
    output logic       bus_idle,
    output logic       frame_active,
    output logic       tx_start,
    output logic       overload_req,
    output logic [2:0] state
);

`ifdef SUSPEND_TX_EN
    typedef enum logic [2:0] {
        INTEG   = 3'd0,
        IDLE    = 3'd1,
        ACTIVE  = 3'd2,
        INTERM  = 3'd3,
        SUSPEND = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        INTEG   = 3'd0,
        IDLE    = 3'd1,
        ACTIVE  = 3'd2,
        INTERM  = 3'd3
    } state_t;

    // The suspend qualifiers only matter when the SUSPEND state is built.
    logic unused_cfg;
    assign unused_cfg = was_tx ^ error_passive;
`endif

    state_t state_q;

    logic recessive_bit;
    logic dominant_bit;
    logic count_valid;

    assign recessive_bit = sample_pt & rx_bit;
    assign dominant_bit  = sample_pt & ~rx_bit;

    // While a clear is pending (cnt_rst_n low), the external counter may still
    // show a stale value. Its compare flags are trusted only after the clear
    // has been released for one quantum.
    assign count_valid = cnt_rst_n;

    assign state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= INTEG;
            cnt_inc      <= 1'b0;
            cnt_rst_n    <= 1'b0;
            bus_idle     <= 1'b0;
            frame_active <= 1'b0;
            tx_start     <= 1'b0;
            overload_req <= 1'b0;
        end else if (Prescale_EN) begin
            // Pulses last one quantum. Any clear request lasts one quantum,
            // except in ACTIVE, where the clear is held for the whole frame.
            cnt_inc      <= 1'b0;
            cnt_rst_n    <= 1'b1;
            tx_start     <= 1'b0;
            overload_req <= 1'b0;

            case (state_q)
                INTEG: begin
                    if (count_valid && eq11) begin
                        state_q   <= IDLE;
                        bus_idle  <= 1'b1;
                        cnt_rst_n <= 1'b0;
                    end else if (recessive_bit) begin
                        cnt_inc <= 1'b1;
                    end else if (dominant_bit) begin
                        // Integration needs consecutive recessive bits.
                        cnt_rst_n <= 1'b0;
                    end
                end

                IDLE: begin
                    if (dominant_bit) begin
                        // Another node sent SOF.
                        state_q      <= ACTIVE;
                        bus_idle     <= 1'b0;
                        frame_active <= 1'b1;
                        cnt_rst_n    <= 1'b0;
                    end else if (recessive_bit && tx_request) begin
                        state_q      <= ACTIVE;
                        bus_idle     <= 1'b0;
                        frame_active <= 1'b1;
                        tx_start     <= 1'b1;
                        cnt_rst_n    <= 1'b0;
                    end
                end

                ACTIVE: begin
                    cnt_rst_n <= 1'b0;
                    // End of frame wins over a coincident bit; that bit is dropped.
                    if (eof_done) begin
                        state_q      <= INTERM;
                        frame_active <= 1'b0;
                    end
                end

                INTERM: begin
                    if (dominant_bit) begin
                        state_q      <= ACTIVE;
                        frame_active <= 1'b1;
                        cnt_rst_n    <= 1'b0;
                        if (counto < 7'd2) begin
                            // Dominant in the first two intermission bits.
                            overload_req <= 1'b1;
                        end else if (tx_request) begin
                            // Dominant in the third bit is taken as SOF.
                            tx_start <= 1'b1;
                        end
                    end else if (count_valid && eq3) begin
                        cnt_rst_n <= 1'b0;
`ifdef SUSPEND_TX_EN
                        if (was_tx && error_passive) begin
                            state_q <= SUSPEND;
                        end else begin
                            state_q  <= IDLE;
                            bus_idle <= 1'b1;
                        end
`else
                        state_q  <= IDLE;
                        bus_idle <= 1'b1;
`endif
                    end else if (recessive_bit) begin
                        cnt_inc <= 1'b1;
                    end
                end

`ifdef SUSPEND_TX_EN
                SUSPEND: begin
                    // A pending local frame must wait; only another node's
                    // SOF ends the suspension early.
                    if (dominant_bit) begin
                        state_q      <= ACTIVE;
                        frame_active <= 1'b1;
                        cnt_rst_n    <= 1'b0;
                    end else if (count_valid && (counto == 7'd8)) begin
                        state_q   <= IDLE;
                        bus_idle  <= 1'b1;
                        cnt_rst_n <= 1'b0;
                    end else if (recessive_bit) begin
                        cnt_inc <= 1'b1;
                    end
                end
`endif

                default: begin
                    // Illegal code: restart bus integration.
                    state_q      <= INTEG;
                    bus_idle     <= 1'b0;
                    frame_active <= 1'b0;
                    cnt_rst_n    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/intermission_seq.md
INTERMISSION_SEQ -- requirements
Module: intermission_seq

Interface
REQ-001 SHALL: clock  in  1  system clock; all flops on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-003 SHALL: Prescale_EN  in  1  time-quantum enable; every state/output update is qualified by it.
REQ-004 SHALL: sample_pt  in  1  bit sample strobe; valid only with Prescale_EN=1 (bit event = both 1).
REQ-005 SHALL: rx_bit  in  1  sampled bus level, 1 = recessive.
REQ-006 SHALL: eof_done  in  1  single-cycle pulse, end-of-frame field finished.
REQ-007 SHALL: tx_request  in  1  level, local frame pending.
REQ-008 SHALL: was_tx  in  1  level, node transmitted the last frame.
REQ-009 SHALL: error_passive  in  1  level, node fault-confinement state.
REQ-010 SHALL: counto  in  7  bit-counter value; eq3, eq11  in  1 each  bit-counter compare flags.
REQ-011 SHALL: cnt_inc  out  1  bit-counter increment, consumer detects rising edge.
REQ-012 SHALL: cnt_rst_n  out  1  bit-counter synchronous clear, active-low.
REQ-013 SHALL: bus_idle, frame_active, tx_start, overload_req  out  1 each; state  out  3  current state.

Function
REQ-014 SHALL: states INTEG=0, IDLE=1, ACTIVE=2, INTERM=3, SUSPEND=4; codes 5-7 return to INTEG at next Prescale_EN cycle.
REQ-015 SHALL: precondition: at least 2 Prescale_EN cycles between bit events; counter flags are consumed one Prescale_EN cycle after cnt_inc.
REQ-016 SHALL: cnt_inc registered; set on a bit event with rx_bit=1 in INTEG, INTERM or SUSPEND; cleared on the next Prescale_EN cycle.
REQ-017 SHALL: cnt_rst_n low while in ACTIVE, on every state transition, and after a dominant bit in INTEG; low for exactly one Prescale_EN cycle in the non-ACTIVE cases.
REQ-018 SHALL: INTEG: dominant bit clears the counter; eq11=1 -> IDLE with counter cleared (11 consecutive recessive bits).
REQ-019 SHALL: IDLE: bus_idle=1; dominant bit -> ACTIVE without tx_start; recessive bit with tx_request=1 -> one-cycle tx_start, then ACTIVE.
REQ-020 SHALL: ACTIVE: frame_active=1; eof_done -> INTERM; eof_done in the same cycle as a bit event takes priority, and the bit is ignored.
REQ-021 SHALL: INTERM: dominant bit with counto<2 -> one-cycle overload_req, then ACTIVE; dominant bit with counto=2 -> ACTIVE as SOF, with tx_start if tx_request=1.
REQ-022 SHALL: INTERM: eq3=1 -> SUSPEND when SUSPEND_TX_EN is defined and was_tx=1 and error_passive=1; otherwise -> IDLE.
REQ-023 SHALL: SUSPEND: tx_request ignored; dominant bit -> ACTIVE without tx_start; counto=8 -> IDLE.
REQ-024 SHALL: counter wrap-around is never relied on; the maximum count used is 11.
REQ-025 SHALL: tx_start and overload_req never asserted in the same cycle.

Reset
REQ-026 SHALL: on reset: state=INTEG, cnt_inc=0, cnt_rst_n=0, bus_idle=0, frame_active=0, tx_start=0, overload_req=0.
REQ-027 SHALL: reset mid-frame or mid-intermission abandons the sequence; after release, integration restarts from counter 0.

Configuration
REQ-028 SHALL: macro SUSPEND_TX_EN defined -> SUSPEND state and REQ-022/023 behaviour present.
REQ-029 SHALL: SUSPEND_TX_EN undefined -> SUSPEND state omitted; INTERM always exits to IDLE; state code 4 treated as illegal per REQ-014.

Verification
REQ-030 SHALL: reset release, 11 recessive bit events -> bus_idle=1 and state=1 after the 11th; dominant at bit 6 -> restart, IDLE after 17 total.
REQ-031 SHALL: IDLE, tx_request=1, recessive bit event -> tx_start high exactly one cycle, state=2, cnt_rst_n=0.
REQ-032 SHALL: eof_done, then dominant bit at counto=1 -> overload_req one cycle, state=2; same with counto=2 -> no overload_req, state=2.
REQ-033 SHALL: SUSPEND_TX_EN defined, was_tx=1, error_passive=1, 3 recessive intermission bits -> state=4; 8 recessive bits -> state=1; tx_request held throughout -> no tx_start before IDLE.
REQ-034 SHALL: eof_done coincident with a dominant bit event in ACTIVE -> state=3, counter cleared, no overload_req.
REQ-035 SHALL: reset asserted in INTERM mid-clock -> state=0 and all outputs at reset values before the next rising edge.
